// File: rtl/excp_commit_pkg.sv
// Shared constants for the writeback commit controller: exception codes,
// ws_op encodings, CSR numbers and the FSM state type.
package excp_commit_pkg;

    // Exception codes reported on wb_ecode
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;

    // ws_op encodings; 5..7 are treated as OP_NONE
    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_CSRRD   = 3'd1;
    localparam logic [2:0] OP_CSRWR   = 3'd2;
    localparam logic [2:0] OP_CSRXCHG = 3'd3;
    localparam logic [2:0] OP_ERTN    = 3'd4;

    // CSR numbers
    localparam logic [13:0] CSR_ERA = 14'h0006;

    // Number of exception sources handled by the priority encoder
    localparam int NUM_EX_SRC = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Ecode for each priority slot, slot 0 being the highest priority:
    // adef > ine > ipe > sys > brk > ale
    function automatic logic [5:0] prio_ecode(input int idx);
        logic [5:0] code;
        case (idx)
            0:       code = ECODE_ADEF;
            1:       code = ECODE_INE;
            2:       code = ECODE_IPE;
            3:       code = ECODE_SYS;
            4:       code = ECODE_BRK;
            default: code = ECODE_ALE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/excp_commit_prio.sv
// Combinational exception priority encoder: {flags, ipe} -> {any_ex, ecode}.
module excp_prio
    import excp_commit_pkg::*;
(
    input  logic [4:0] ex_flags,   // {adef, ine, sys, brk, ale}
    input  logic       ipe,
    output logic       any_ex,
    output logic [5:0] ecode
);

    logic [NUM_EX_SRC-1:0] req;
    logic [NUM_EX_SRC-1:0] grant;
    logic [5:0]            ecode_term [NUM_EX_SRC];

    // Requests ordered by priority, bit 0 highest
    assign req = {ex_flags[0], ex_flags[1], ex_flags[2], ipe, ex_flags[3], ex_flags[4]};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EX_SRC; gi++) begin : g_grant
            localparam logic [NUM_EX_SRC-1:0] HIGHER = (NUM_EX_SRC'(1) << gi) - NUM_EX_SRC'(1);
            assign grant[gi]      = req[gi] & ~(|(req & HIGHER));
            assign ecode_term[gi] = {6{grant[gi]}} & prio_ecode(gi);
        end
    endgenerate

    assign any_ex = |req;

    // Merge the one-hot granted ecode
    always_comb begin
        ecode = '0;
        for (int i = 0; i < NUM_EX_SRC; i++) begin
            ecode = ecode | ecode_term[i];
        end
    end

endmodule

// File: rtl/excp_commit.sv
// Writeback commit controller: drives CSR read/write strobes, exception and
// ertn events, and a registered flush plus fetch redirect held until acked.
module excp_commit
    import excp_commit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    input  logic [31:0] ws_pc,
    input  logic [2:0]  ws_op,
    input  logic [13:0] ws_csr_num,
    input  logic [31:0] ws_rd_value,
    input  logic [31:0] ws_rj_value,
    input  logic [4:0]  ws_ex_flags,
    input  logic [1:0]  cur_plv,
    output logic        ws_allowin,
    output logic        csr_re,
    output logic [13:0] csr_rnum,
    input  logic [31:0] csr_rdata,
    output logic [3:0]  csr_we,
    output logic [13:0] csr_wnum,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wdata,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic        ertn_flush,
    input  logic [31:0] ex_entry,
    output logic [31:0] ws_rf_wdata,
    output logic        ws_rf_we_kill,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack
);

    state_t      state_reg, state_next;
    logic [31:0] target_reg, target_next;

    logic [2:0]  op_eff;
    logic        is_csr_op;
    logic        is_csr_wr;
    logic        is_ertn;
    logic        commit;
    logic        ipe;
    logic        any_ex;
    logic [5:0]  ecode;

    // Undefined op codes collapse to "no op"
    assign op_eff    = (ws_op > OP_ERTN) ? OP_NONE : ws_op;
    assign is_csr_op = (op_eff == OP_CSRRD) || (op_eff == OP_CSRWR) || (op_eff == OP_CSRXCHG);
    assign is_csr_wr = (op_eff == OP_CSRWR) || (op_eff == OP_CSRXCHG);
    assign is_ertn   = (op_eff == OP_ERTN);

    // Only an idle controller commits; anything in WB while redirecting is dropped
    assign commit = ws_valid & (state_reg == ST_IDLE);

    // Privileged ops (csr*/ertn) trap at user level
    assign ipe = (op_eff != OP_NONE) & (cur_plv == 2'd3);

    excp_prio u_prio (
        .ex_flags (ws_ex_flags),
        .ipe      (ipe),
        .any_ex   (any_ex),
        .ecode    (ecode)
    );

    // CSR port and exception event muxing, all combinational in the commit cycle
    always_comb begin
        csr_re        = commit & is_csr_op;
        csr_rnum      = is_ertn ? CSR_ERA : ws_csr_num;
        csr_we        = (commit & ~any_ex & is_csr_wr) ? 4'hF : 4'h0;
        csr_wnum      = ws_csr_num;
        csr_wmask     = (op_eff == OP_CSRXCHG) ? ws_rj_value : 32'hFFFF_FFFF;
        csr_wdata     = ws_rd_value;
        wb_ex         = commit & any_ex;
        wb_ecode      = ecode;
        wb_esubcode   = 9'd0;
        wb_pc         = ws_pc;
        ertn_flush    = commit & ~any_ex & is_ertn;
        ws_rf_wdata   = csr_rdata;
        ws_rf_we_kill = ws_valid & (~commit | any_ex);
    end

    // Next-state logic; the redirect target is captured when leaving IDLE
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        case (state_reg)
            ST_IDLE: begin
                if (wb_ex | ertn_flush) begin
                    state_next  = ST_FLUSH;
                    target_next = wb_ex ? ex_entry : csr_rdata;
                end
            end
            ST_FLUSH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and target registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            target_reg <= 32'd0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
        end
    end

    assign flush          = (state_reg == ST_FLUSH);
    assign redirect_valid = (state_reg != ST_IDLE);
    assign redirect_pc    = target_reg;
    assign ws_allowin     = (state_reg == ST_IDLE);

endmodule

// File: tb/tb_excp_commit.sv
// Self-checking bench for excp_commit: directed test-plan steps followed by
// randomized cycles, all checked against a cycle-level reference model.
module tb_excp_commit;

    logic        clk;
    logic        reset;
    logic        ws_valid;
    logic [31:0] ws_pc;
    logic [2:0]  ws_op;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_rd_value;
    logic [31:0] ws_rj_value;
    logic [4:0]  ws_ex_flags;
    logic [1:0]  cur_plv;
    logic        ws_allowin;
    logic        csr_re;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rdata;
    logic [3:0]  csr_we;
    logic [13:0] csr_wnum;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        ertn_flush;
    logic [31:0] ex_entry;
    logic [31:0] ws_rf_wdata;
    logic        ws_rf_we_kill;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_no = 0;

    // Reference model state: busy while a redirect is outstanding, and the
    // number of cycles spent busy so far (1 = the flush cycle).
    bit          m_busy;
    int          m_cyc;
    logic [31:0] m_tgt;

    excp_commit dut (
        .clk            (clk),
        .reset          (reset),
        .ws_valid       (ws_valid),
        .ws_pc          (ws_pc),
        .ws_op          (ws_op),
        .ws_csr_num     (ws_csr_num),
        .ws_rd_value    (ws_rd_value),
        .ws_rj_value    (ws_rj_value),
        .ws_ex_flags    (ws_ex_flags),
        .cur_plv        (cur_plv),
        .ws_allowin     (ws_allowin),
        .csr_re         (csr_re),
        .csr_rnum       (csr_rnum),
        .csr_rdata      (csr_rdata),
        .csr_we         (csr_we),
        .csr_wnum       (csr_wnum),
        .csr_wmask      (csr_wmask),
        .csr_wdata      (csr_wdata),
        .wb_ex          (wb_ex),
        .wb_ecode       (wb_ecode),
        .wb_esubcode    (wb_esubcode),
        .wb_pc          (wb_pc),
        .ertn_flush     (ertn_flush),
        .ex_entry       (ex_entry),
        .ws_rf_wdata    (ws_rf_wdata),
        .ws_rf_we_kill  (ws_rf_we_kill),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ack   (redirect_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    // Architectural expectations from the instruction rules
    function automatic int eff_op();
        return (ws_op > 3'd4) ? 0 : int'(ws_op);
    endfunction

    function automatic bit m_commit();
        return ws_valid && !m_busy;
    endfunction

    // First exception found in priority order; returns 0 if none
    function automatic logic [5:0] m_ecode(output bit hit);
        bit         src  [6];
        logic [5:0] code [6];
        src[0] = ws_ex_flags[4];                      code[0] = 6'h08;
        src[1] = ws_ex_flags[3];                      code[1] = 6'h0D;
        src[2] = (eff_op() != 0) && (cur_plv == 2'd3); code[2] = 6'h0E;
        src[3] = ws_ex_flags[2];                      code[3] = 6'h0B;
        src[4] = ws_ex_flags[1];                      code[4] = 6'h0C;
        src[5] = ws_ex_flags[0];                      code[5] = 6'h09;
        hit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (src[i]) begin
                hit = 1'b1;
                return code[i];
            end
        end
        return 6'h00;
    endfunction

    task automatic drive(input bit v, input logic [2:0] op, input logic [13:0] num,
                         input logic [31:0] rd, input logic [31:0] rj, input logic [4:0] fl,
                         input logic [1:0] plv, input logic [31:0] rdata,
                         input logic [31:0] entry, input logic [31:0] pc, input bit ack);
        ws_valid     = v;
        ws_op        = op;
        ws_csr_num   = num;
        ws_rd_value  = rd;
        ws_rj_value  = rj;
        ws_ex_flags  = fl;
        cur_plv      = plv;
        csr_rdata    = rdata;
        ex_entry     = entry;
        ws_pc        = pc;
        redirect_ack = ack;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic model_check();
        bit         ex;
        logic [5:0] code;
        bit         c;
        int         op;
        code = m_ecode(ex);
        c    = m_commit();
        op   = eff_op();
        $display("cycle %0d: valid=%0b op=%0d flags=%05b plv=%0d ack=%0b rst=%0b busy=%0b",
                 cyc_no, ws_valid, ws_op, ws_ex_flags, cur_plv, redirect_ack, reset, m_busy);
        chk("allowin", ws_allowin, !m_busy);
        chk("flush", flush, (m_busy && m_cyc == 1));
        chk("redirect_valid", redirect_valid, m_busy);
        if (m_busy) chk("redirect_pc", redirect_pc, m_tgt);
        chk("csr_re", csr_re, (c && op >= 1 && op <= 3));
        chk("csr_we", csr_we, ((c && !ex && (op == 2 || op == 3)) ? 4'hF : 4'h0));
        chk("wb_ex", wb_ex, (c && ex));
        chk("ertn_flush", ertn_flush, (c && !ex && op == 4));
        chk("rf_wdata", ws_rf_wdata, csr_rdata);
        if (c) chk("rf_we_kill", ws_rf_we_kill, ex);
        if (c && ex) begin
            chk("ecode", wb_ecode, code);
            chk("esubcode", wb_esubcode, 9'd0);
            chk("wb_pc", wb_pc, ws_pc);
        end
        if (c && !ex && (op == 2 || op == 3)) begin
            chk("wnum", csr_wnum, ws_csr_num);
            chk("wdata", csr_wdata, ws_rd_value);
            chk("wmask", csr_wmask, (op == 3) ? ws_rj_value : 32'hFFFF_FFFF);
        end
        if (c && op >= 1 && op <= 3) chk("rnum", csr_rnum, ws_csr_num);
        if (c && op == 4) chk("rnum_era", csr_rnum, 14'h0006);
    endtask

    // Clock edge plus model update from the inputs held across it
    task automatic advance();
        bit         ex;
        logic [5:0] code;
        bit         c;
        code = m_ecode(ex);
        c    = m_commit();
        @(posedge clk);
        cyc_no++;
        if (reset) begin
            m_busy = 1'b0;
            m_cyc  = 0;
            m_tgt  = 32'd0;
        end else if (!m_busy) begin
            if (c && (ex || eff_op() == 4)) begin
                m_busy = 1'b1;
                m_cyc  = 1;
                m_tgt  = ex ? ex_entry : csr_rdata;
            end
        end else if (m_cyc >= 2 && redirect_ack) begin
            m_busy = 1'b0;
        end else begin
            m_cyc++;
        end
        #1;
    endtask

    initial begin
        m_busy = 1'b0;
        m_cyc  = 0;
        m_tgt  = 32'd0;
        reset  = 1'b1;
        drive(0, 3'd0, 14'd0, 32'd0, 32'd0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        settle();
        chk("rst_flush", flush, 1'b0);
        chk("rst_redirect_valid", redirect_valid, 1'b0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_allowin", ws_allowin, 1'b1);
        advance();
        reset = 1'b0;

        // csrwr CSR 0x30, rd=0x1234, plv 0
        drive(1, 3'd2, 14'h30, 32'h1234, 32'h0, 5'd0, 2'd0, 32'h5555_AAAA, 32'h0, 32'h1C00_0000, 0);
        settle();
        chk("wr_we", csr_we, 4'hF);
        chk("wr_wmask", csr_wmask, 32'hFFFF_FFFF);
        chk("wr_wdata", csr_wdata, 32'h1234);
        chk("wr_re", csr_re, 1'b1);
        chk("wr_rf_wdata", ws_rf_wdata, 32'h5555_AAAA);
        model_check();
        advance();
        drive(0, 3'd0, 14'h0, 32'h0, 32'h0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0);
        settle();
        chk("wr_no_flush", flush, 1'b0);
        model_check();
        advance();

        // csrxchg rj=0xFF rd=0xABCD
        drive(1, 3'd3, 14'h30, 32'hABCD, 32'h0000_00FF, 5'd0, 2'd0, 32'h0, 32'h0, 32'h1C00_0004, 0);
        settle();
        chk("xchg_wmask", csr_wmask, 32'h0000_00FF);
        chk("xchg_wdata", csr_wdata, 32'hABCD);
        model_check();
        advance();

        // syscall at 0x1C00_0100, entry 0x1C00_8000
        drive(1, 3'd0, 14'h0, 32'h0, 32'h0, 5'b00100, 2'd0, 32'h0, 32'h1C00_8000, 32'h1C00_0100, 0);
        settle();
        chk("sys_wb_ex", wb_ex, 1'b1);
        chk("sys_ecode", wb_ecode, 6'h0B);
        chk("sys_pc", wb_pc, 32'h1C00_0100);
        model_check();
        advance();
        // Younger csrwr in WB during FLUSH must be dropped; early ack ignored
        drive(1, 3'd2, 14'h30, 32'h9999, 32'h0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h1C00_0104, 1);
        settle();
        chk("sys_flush", flush, 1'b1);
        chk("sys_drop_we", csr_we, 4'h0);
        chk("sys_redirect_pc", redirect_pc, 32'h1C00_8000);
        model_check();
        advance();
        redirect_ack = 1'b0;
        settle();
        chk("sys_wait_valid", redirect_valid, 1'b1);
        chk("sys_wait_flush", flush, 1'b0);
        model_check();
        advance();
        redirect_ack = 1'b1;
        settle();
        model_check();
        advance();
        drive(0, 3'd0, 14'h0, 32'h0, 32'h0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0);
        settle();
        chk("sys_ack_drop", redirect_valid, 1'b0);
        model_check();
        advance();

        // ertn with ERA = 0x1C00_0104
        drive(1, 3'd4, 14'h0, 32'h0, 32'h0, 5'd0, 2'd0, 32'h1C00_0104, 32'h0, 32'h1C00_0200, 0);
        settle();
        chk("ertn_flush", ertn_flush, 1'b1);
        chk("ertn_rnum", csr_rnum, 14'h0006);
        chk("ertn_we", csr_we, 4'h0);
        model_check();
        advance();
        drive(0, 3'd0, 14'h0, 32'h0, 32'h0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0);
        settle();
        chk("ertn_redirect_pc", redirect_pc, 32'h1C00_0104);
        model_check();
        advance();
        redirect_ack = 1'b1;
        settle();
        model_check();
        advance();
        redirect_ack = 1'b0;

        // adef+sys on csrwr at plv 3 -> adef wins
        drive(1, 3'd2, 14'h30, 32'h1, 32'h0, 5'b10100, 2'd3, 32'h0, 32'h1C00_8000, 32'h1C00_0300, 0);
        settle();
        chk("prio_adef", wb_ecode, 6'h08);
        model_check();
        advance();
        drive(0, 3'd0, 14'h0, 32'h0, 32'h0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0);
        settle(); model_check(); advance();
        redirect_ack = 1'b1;
        settle(); model_check(); advance();
        redirect_ack = 1'b0;

        // csrwr alone at plv 3 -> ipe
        drive(1, 3'd2, 14'h30, 32'h1, 32'h0, 5'd0, 2'd3, 32'h0, 32'h1C00_8000, 32'h1C00_0400, 0);
        settle();
        chk("ipe_ecode", wb_ecode, 6'h0E);
        chk("ipe_we", csr_we, 4'h0);
        chk("ipe_kill", ws_rf_we_kill, 1'b1);
        model_check();
        advance();

        // Reset while in WAIT, no ack
        drive(0, 3'd0, 14'h0, 32'h0, 32'h0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 0);
        settle(); model_check(); advance();
        settle();
        chk("wait_before_rst", redirect_valid, 1'b1);
        model_check();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        settle();
        chk("rst_wait_valid", redirect_valid, 1'b0);
        chk("rst_wait_allowin", ws_allowin, 1'b1);
        model_check();
        advance();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 8),
                  3'($urandom_range(0, 7)),
                  14'($urandom),
                  $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
                  2'($urandom),
                  $urandom, $urandom, $urandom,
                  $urandom_range(0, 1) == 1);
            reset = ($urandom_range(0, 49) == 0);
            settle();
            model_check();
            advance();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/excp_commit.md
# excp_commit

Writeback-stage commit controller that drives the requester side of the CSR file's interface. It turns committed CSR instructions (csrrd/csrwr/csrxchg), `ertn`, and exception flags carried down the pipeline into CSR read/write strobes and the `wb_ex`/`ertn_flush` events. It also produces a registered pipeline flush and a fetch redirect, held until the frontend acknowledges it. It sits between the WB pipeline register and the CSR file.

## Interface
- No parameters; ecode and CSR-number constants come from `myCPU.vh`.
- `clk` in 1 — single clock
- `reset` in 1 — synchronous, active-high
- `ws_valid` in 1 — WB stage holds an instruction
- `ws_pc` in 32 — PC of the WB instruction
- `ws_op` in 3 — 0 none, 1 csrrd, 2 csrwr, 3 csrxchg, 4 ertn
- `ws_csr_num` in 14 — CSR number from the instruction
- `ws_rd_value` in 32 — rd operand, used as write data
- `ws_rj_value` in 32 — rj operand, used as the csrxchg mask
- `ws_ex_flags` in 5 — {adef, ine, sys, brk, ale} from earlier stages
- `cur_plv` in 2 — current CRMD.PLV
- `ws_allowin` out 1 — WB may accept or commit
- `csr_re` out 1 / `csr_rnum` out 14 / `csr_rdata` in 32 — CSR read port
- `csr_we` out 4 / `csr_wnum` out 14 / `csr_wmask` out 32 / `csr_wdata` out 32 — CSR write port
- `wb_ex` out 1 / `wb_ecode` out 6 / `wb_esubcode` out 9 / `wb_pc` out 32 — exception event
- `ertn_flush` out 1 — ertn commit
- `ex_entry` in 32 — exception entry from the CSR file
- `ws_rf_wdata` out 32 — old CSR value for rd (csr ops)
- `ws_rf_we_kill` out 1 — suppress the rd write of the committing instruction
- `flush` out 1 — one-cycle pipeline flush
- `redirect_valid` out 1 / `redirect_pc` out 32 / `redirect_ack` in 1 — fetch redirect handshake

## Operation
- Commit condition: `commit = ws_valid & (state==IDLE)`. When `state!=IDLE`, any instruction in WB is discarded and has no CSR effect.
- Exception priority: adef (0x08) > ine (0x0D) > ipe (0x0E, raised when `ws_op` is 1–4 and `cur_plv==3`) > sys (0x0B) > brk (0x0C) > ale (0x09). `wb_esubcode` is always 0.
- `wb_ex = commit & any_ex`, and `wb_pc = ws_pc`. An excepting instruction performs no CSR write, no ertn, and sets `ws_rf_we_kill=1`.
- CSR read: `csr_re = commit & ws_op∈{1,2,3}`, with `csr_rnum = ws_csr_num`. For ertn, `csr_rnum = CSR_ERA`. `ws_rf_wdata = csr_rdata`.
- CSR write: when `commit & ~any_ex & ws_op∈{2,3}`:
  - `csr_we = 4'hF`, `csr_wnum = ws_csr_num`, `csr_wdata = ws_rd_value`.
  - `csr_wmask` is `32'hFFFFFFFF` for csrwr and `ws_rj_value` for csrxchg.
  - Otherwise `csr_we = 0`.
- `ertn_flush = commit & ~any_ex & ws_op==4`.
- FSM:
  - IDLE → FLUSH on `wb_ex | ertn_flush`. The target is latched at this point: `ex_entry` for an exception, `csr_rdata` (ERA) for ertn.
  - FLUSH → WAIT, unconditionally after 1 cycle.
  - WAIT → IDLE on `redirect_ack`.
- `flush = (state==FLUSH)`.
- `redirect_valid = (state!=IDLE)`. `redirect_pc` is the latched target, stable while `redirect_valid` is high.
- `ws_allowin = (state==IDLE)`.
- CSR ops without an exception cause no flush.

## Timing
- CSR strobes, `wb_ex` and `ertn_flush` are combinational in commit cycle T; the CSR file updates at the end of T.
- `flush` and `redirect_valid` rise at T+1. `flush` lasts exactly 1 cycle.
- `redirect_valid` stays high from T+1 until the cycle `redirect_ack` is sampled high, and drops in the following cycle.
- An ack sampled during FLUSH is held off; the transition to IDLE happens only from WAIT.
- Earliest next commit is T+3 (ack at T+2).
- Reset values: state=IDLE, `flush=0`, `redirect_valid=0`, `redirect_pc=0`. All strobes are 0 because `ws_valid` is gated by the state.
- Reset in FLUSH or WAIT returns to IDLE in the next cycle and drops `redirect_valid` with no ack required.
- `ws_op` values 5–7 behave as 0.

## Structure
- Ecode values (ADEF, ALE, SYS, BRK, INE, IPE), `ws_op` encodings and CSR numbers go in shared `myCPU.vh`.
- Sub-module `excp_prio`: a combinational priority encoder from {flags, ipe} to {any_ex, ecode}.
- FSM, target latch and CSR port muxing are in the top module.

## Test plan
- csrwr, CSR 0x30, rd=0x1234, plv 0 → `csr_we=F`, `wmask=FFFFFFFF`, `wdata=0x1234`, `csr_re=1`, `ws_rf_wdata=csr_rdata`, `flush` stays 0.
- csrxchg, rj=0x0000_00FF, rd=0xABCD → `csr_wmask=0xFF`, `csr_wdata=0xABCD`.
- syscall at pc 0x1C00_0100, `ex_entry=0x1C00_8000` → `wb_ex=1`, `ecode=0x0B`, `wb_pc=0x1C00_0100` at T; `flush=1` at T+1; `redirect_pc=0x1C00_8000` held until ack; younger WB instruction dropped.
- ertn with `csr_rdata=0x1C00_0104` → `ertn_flush=1`, `csr_rnum=ERA`, `redirect_pc=0x1C00_0104`, `csr_we=0`.
- flags adef+sys together, plus csrwr at plv 3 → ecode 0x08; csrwr alone at plv 3 → ecode 0x0E with `csr_we=0` and `ws_rf_we_kill=1`.
- reset asserted in WAIT with no ack → `redirect_valid=0` next cycle, `ws_allowin=1`.
